// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control stage of a stopwatch. It takes the debounced start and lap button
// levels, turns each into a single-cycle press pulse, and runs a four-state
// run/pause/lap machine. While running, a prescaler divides the system clock
// down to a one-second tick that advances an MM:SS BCD count. A lap latch
// can freeze a copy of the count for display while counting continues.
//
// Parameters
//   TICK_DIV   clk cycles per one-second count tick (>= 2)
//   CNT_W      prescaler width, 2**CNT_W >= TICK_DIV
//
// Ports
//   clk          in   system clock, all state on posedge
//   rst_n        in   asynchronous active-low reset
//   start_db     in   debounced start button level, 1 = pressed
//   lap_db       in   debounced lap button level, 1 = pressed
//   disp_bcd     out  {min_tens,min_ones,sec_tens,sec_ones}, live or lap-frozen
//   running      out  1 in RUN or LAP
//   lap_active   out  1 in LAP (display frozen)
//   state        out  IDLE=0, RUN=1, PAUSE=2, LAP=3
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_db,
    input  logic        lap_db,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    logic [1:0]       state_q,      state_d;
    logic             start_prev_q, start_prev_d;
    logic             lap_prev_q,   lap_prev_d;
    logic [CNT_W-1:0] presc_q,      presc_d;
    logic [15:0]      cnt_q,        cnt_d;
    logic [15:0]      lap_q,        lap_d;

    logic        start_p;
    logic        lap_p;
    logic        counting;
    logic        tick;
    logic        clear_cnt;
    logic [15:0] cnt_inc;

    // A press is the first cycle the level is seen high. The previous-level
    // flops reset to 1 so a button held through reset never produces a pulse.
    always_comb begin
        start_p      = start_db & ~start_prev_q;
        lap_p        = lap_db & ~lap_prev_q;
        start_prev_d = start_db;
        lap_prev_d   = lap_db;
    end

    // Run/pause/lap machine. Start wins when both buttons fire together.
    // The lap latch takes the count as it stands before this edge's tick,
    // i.e. the value on the display in the cycle the lap press was seen.
    always_comb begin
        state_d   = state_q;
        lap_d     = lap_q;
        clear_cnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_p) begin
                    state_d = ST_PAUSE;
                end else if (lap_p) begin
                    state_d = ST_LAP;
                    lap_d   = cnt_q;
                end
            end
            ST_PAUSE: begin
                if (start_p) begin
                    state_d = ST_RUN;
                end else if (lap_p) begin
                    state_d   = ST_IDLE;
                    clear_cnt = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_p)    state_d = ST_PAUSE;
                else if (lap_p) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Prescaler runs off the current state, so a tick still lands on the
    // same edge that leaves RUN/LAP for PAUSE. It holds in PAUSE so a
    // resumed run picks up the partial second where it left off.
    always_comb begin
        counting = (state_q == ST_RUN) || (state_q == ST_LAP);
        tick     = counting && (presc_q == TICK_MAX);
        if (clear_cnt || (state_q == ST_IDLE)) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = presc_q + CNT_W'(1);
        end else begin
            presc_d = presc_q;
        end
    end

    // One-second BCD increment with ripple carry through the four digits.
    // 59:59 rolls over to 00:00.
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q[3:0] != 4'd9) begin
            cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
        end else begin
            cnt_inc[3:0] = 4'd0;
            if (cnt_q[7:4] != 4'd5) begin
                cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
            end else begin
                cnt_inc[7:4] = 4'd0;
                if (cnt_q[11:8] != 4'd9) begin
                    cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
                end else begin
                    cnt_inc[11:8] = 4'd0;
                    if (cnt_q[15:12] != 4'd5) begin
                        cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
                    end else begin
                        cnt_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    // Count register: cleared when PAUSE falls back to IDLE, else advanced
    // on each tick.
    always_comb begin
        if (clear_cnt) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_inc;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // All state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            lap_prev_q   <= 1'b1;
            presc_q      <= '0;
            cnt_q        <= '0;
            lap_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            lap_prev_q   <= lap_prev_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            lap_q        <= lap_d;
        end
    end

    // Outputs decode registered state only; no button input reaches them.
    always_comb begin
        disp_bcd   = (state_q == ST_LAP) ? lap_q : cnt_q;
        running    = (state_q == ST_RUN) || (state_q == ST_LAP);
        lap_active = (state_q == ST_LAP);
        state      = state_q;
    end

endmodule
